// File: rtl/key_event_ctrl_if.sv
// Event handshake between key_event_ctrl (master) and the game logic (slave).
interface key_event_ctrl_if;
    logic       ev_valid;
    logic [7:0] ev_ascii;
    logic       ev_ready;

    modport master (output ev_valid, ev_ascii, input ev_ready);
    modport slave  (input ev_valid, ev_ascii, output ev_ready);
endinterface

// File: rtl/key_event_ctrl.sv
// PS/2 scan-code sequencer: strips prefixes, tracks shift, suppresses typematic
// repeats, looks up fresh make codes and queues non-NUL ASCII events.
module key_event_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             letter_case,
    output logic [7:0]       scan_code,
    input  logic [7:0]       ascii_code,
    key_event_ctrl_if.master ev,
    output logic             overflow,
    input  logic             ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] CODE_BRK       = 8'hF0;
    localparam logic [7:0] CODE_EXT       = 8'hE0;
    localparam logic [7:0] CODE_SHIFT_L   = 8'h12;
    localparam logic [7:0] CODE_SHIFT_R   = 8'h59;
    localparam logic [7:0] CODE_SELF_TEST = 8'hAA;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t        state, state_nxt;
    logic          shift_l, shift_r, shift_l_nxt, shift_r_nxt;
    logic [7:0]    held_code;
    logic          held_valid;
    logic          lookup_pend;
    logic          is_ctrl, is_shift, make_hit, brk_hit, self_test, accept_make;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ev_valid, push_req, pop, full, do_push, drop;

    // Receiver status/ack bytes that must never be treated as key codes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        is_ctrl = 1'b0;
        case (rx_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl = 1'b1;
            default: is_ctrl = 1'b0;
        endcase
    end

    assign is_shift = (rx_data == CODE_SHIFT_L) || (rx_data == CODE_SHIFT_R);

    always_comb begin
        state_nxt = state;
        make_hit  = 1'b0;
        brk_hit   = 1'b0;
        self_test = 1'b0;
        if (rx_valid) begin
            if (is_ctrl) begin
                state_nxt = IDLE;
                self_test = (rx_data == CODE_SELF_TEST);
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_data == CODE_BRK)      state_nxt = BRK;
                        else if (rx_data == CODE_EXT) state_nxt = EXT;
                        else                          make_hit  = 1'b1;
                    end
                    BRK: begin
                        brk_hit   = 1'b1;
                        state_nxt = IDLE;
                    end
                    EXT:     state_nxt = (rx_data == CODE_BRK) ? EXT_BRK : IDLE;
                    EXT_BRK: state_nxt = IDLE;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        shift_l_nxt = shift_l;
        shift_r_nxt = shift_r;
        if (self_test) begin
            shift_l_nxt = 1'b0;
            shift_r_nxt = 1'b0;
        end else if (make_hit || brk_hit) begin
            if (rx_data == CODE_SHIFT_L) shift_l_nxt = make_hit;
            if (rx_data == CODE_SHIFT_R) shift_r_nxt = make_hit;
        end
    end

    // A repeat of the currently held key is the keyboard's typematic stream.
    assign accept_make = make_hit && !is_shift && !(held_valid && (rx_data == held_code));

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_l     <= 1'b0;
            shift_r     <= 1'b0;
            letter_case <= 1'b0;
            held_code   <= 8'h00;
            held_valid  <= 1'b0;
            scan_code   <= 8'h00;
            lookup_pend <= 1'b0;
        end else begin
            shift_l     <= shift_l_nxt;
            shift_r     <= shift_r_nxt;
            letter_case <= shift_l_nxt | shift_r_nxt;
            lookup_pend <= accept_make;
            if (self_test) begin
                held_valid <= 1'b0;
            end else if (accept_make) begin
                held_code  <= rx_data;
                held_valid <= 1'b1;
                scan_code  <= rx_data;
            end else if (brk_hit && (rx_data == held_code)) begin
                held_valid <= 1'b0;
            end
        end
    end

    // The translator answer for scan_code is ready one cycle after the make.
    assign push_req = lookup_pend && (ascii_code != 8'h00);
    assign ev_valid = (count != '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = ev_valid && ev.ev_ready;
    assign do_push  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        // NOTE: queue storage is not reset; the occupancy count alone decides what is valid.
        if (do_push) mem[wr_ptr] <= ascii_code;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear request must stay visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    assign ev.ev_valid = ev_valid;
    assign ev.ev_ascii = ev_valid ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomized scoreboard bench for key_event_ctrl with a prefix-buffer reference
// model and a bench-side scan-code translator.
module tb_key_event_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       letter_case;
    logic [7:0] scan_code;
    logic [7:0] ascii_code;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    key_event_ctrl_if ev ();

    key_event_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .letter_case (letter_case),
        .scan_code   (scan_code),
        .ascii_code  (ascii_code),
        .ev          (ev.master),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    // Shift codes and 75 map to non-zero so a wrongful lookup produces a stray event.
    function automatic logic [7:0] xlate(input logic [7:0] sc, input logic up);
        case (sc)
            8'h16:   return up ? 8'h21 : 8'h31;
            8'h1E:   return up ? 8'h40 : 8'h32;
            8'h26:   return up ? 8'h23 : 8'h33;
            8'h25:   return up ? 8'h24 : 8'h34;
            8'h2E:   return up ? 8'h25 : 8'h35;
            8'h46:   return up ? 8'h28 : 8'h39;
            8'h22:   return up ? 8'h58 : 8'h78;
            8'h44:   return up ? 8'h4F : 8'h6F;
            8'h1C:   return up ? 8'h41 : 8'h61;
            8'h75:   return 8'h38;
            8'h12:   return 8'h53;
            8'h59:   return 8'h53;
            default: return 8'h00;
        endcase
    endfunction

    always_comb ascii_code = xlate(scan_code, letter_case);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else             n_pass++;
    endtask

    // Reference model: pending prefix bytes, set of held shift keys, last held key.
    logic [7:0] prefix_q[$];
    bit         shift_down[int];
    int         held_key;
    logic [7:0] exp_scan;
    bit         exp_ovf;
    logic [7:0] exp_q[$];
    logic [7:0] burst_q[$];

    function automatic bit model_lc();
        return shift_down.size() != 0;
    endfunction

    function automatic bit is_ctrl_byte(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    task automatic model_reset();
        prefix_q.delete();
        shift_down.delete();
        held_key = -1;
        exp_scan = 8'h00;
        exp_ovf  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_make(input logic [7:0] b);
        logic [7:0] a;
        if (b == 8'h12 || b == 8'h59) begin
            shift_down[int'(b)] = 1'b1;
        end else if (held_key != int'(b)) begin
            held_key = int'(b);
            exp_scan = b;
            a = xlate(b, model_lc());
            if (a != 8'h00) begin
                if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
                else                       exp_q.push_back(a);
            end
        end
    endtask

    task automatic model_break(input logic [7:0] b);
        if (shift_down.exists(int'(b))) shift_down.delete(int'(b));
        if (held_key == int'(b)) held_key = -1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (is_ctrl_byte(b)) begin
            prefix_q.delete();
            if (b == 8'hAA) begin
                shift_down.delete();
                held_key = -1;
            end
        end else if (prefix_q.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0) prefix_q.push_back(b);
            else                          model_make(b);
        end else if (prefix_q.size() == 1 && prefix_q[0] == 8'hF0) begin
            model_break(b);
            prefix_q.delete();
        end else if (prefix_q.size() == 1 && b == 8'hF0) begin
            prefix_q.push_back(b);
        end else begin
            prefix_q.delete();
        end
    endtask

    task automatic check_keys(input string tag);
        check({tag, "_letter_case"}, letter_case, model_lc());
        check({tag, "_scan_code"}, scan_code, exp_scan);
    endtask

    // One byte, then two idle cycles so its lookup has settled before the model runs.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        model_byte(b);
        check_keys("byte");
    endtask

    task automatic press(input logic [7:0] b);
        send_byte(b);
        send_byte(8'hF0);
        send_byte(b);
    endtask

    // Back-to-back bytes with the consumer stalled so the model may catch up afterwards.
    task automatic do_burst();
        logic saved;
        saved       = ev.ev_ready;
        ev.ev_ready = 1'b0;
        foreach (burst_q[i]) begin
            @(negedge clk);
            rx_data  = burst_q[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        foreach (burst_q[i]) model_byte(burst_q[i]);
        check_keys("burst");
        burst_q.delete();
        ev.ev_ready = saved;
    endtask

    task automatic drain(input string tag);
        ev.ev_ready = 1'b1;
        repeat (DEPTH + 6) @(negedge clk);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_ev_valid_idle"}, ev.ev_valid, 1'b0);
    endtask

    // Scoreboard monitor: every accepted event must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (resetn && ev.ev_valid && ev.ev_ready) begin
                check("ev_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("ev_ascii", ev.ev_ascii, exp_q.pop_front());
            end
        end
    end

    logic [7:0] pool [20];

    initial begin
        pool = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h46, 8'h22, 8'h44, 8'h1C, 8'h75,
                 8'h5A, 8'h12, 8'h59, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'h00, 8'hFF};
        ev.ev_ready = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_letter_case", letter_case, 1'b0);
        check("rst_scan_code", scan_code, 8'h00);
        check("rst_ev_valid", ev.ev_valid, 1'b0);
        check("rst_ev_ascii", ev.ev_ascii, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        resetn = 1'b1;

        // 1: single make, two-edge latency, break gives nothing.
        @(negedge clk);
        rx_data  = 8'h16;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("lat_not_yet", ev.ev_valid, 1'b0);
        @(negedge clk);
        check("lat_ev_valid", ev.ev_valid, 1'b1);
        check("lat_ev_ascii", ev.ev_ascii, 8'h31);
        model_byte(8'h16);
        check_keys("t1");
        ev.ev_ready = 1'b1;
        send_byte(8'hF0);
        send_byte(8'h16);
        drain("t1");

        // 2: typematic repeats suppressed, re-press after break accepted.
        send_byte(8'h22); send_byte(8'h22); send_byte(8'h22);
        send_byte(8'hF0); send_byte(8'h22); send_byte(8'h22);
        drain("t2");

        // 3: shift drives letter_case; extended shift ignored; unmapped code dropped.
        send_byte(8'h12);
        send_byte(8'h44);
        check("t3_upper", letter_case, 1'b1);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'h5A);
        send_byte(8'hF0); send_byte(8'h44);
        send_byte(8'hF0); send_byte(8'h12);
        check("t3_lower", letter_case, 1'b0);
        send_byte(8'hE0); send_byte(8'h12);
        check("t3_ext_shift", letter_case, 1'b0);
        drain("t3");

        // 4: extended make/break produce nothing; the FSM is back in IDLE for 1E.
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'h1E);
        drain("t4");

        // 5: fill with consumer stalled, fifth event dropped even with ovf_clr on that cycle.
        ev.ev_ready = 1'b0;
        press(8'h16); press(8'h1E); press(8'h26); press(8'h25);
        check("t5_full_no_ovf", overflow, exp_ovf);
        @(negedge clk);
        rx_data  = 8'h2E;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        ovf_clr  = 1'b1;
        @(negedge clk);
        ovf_clr  = 1'b0;
        model_byte(8'h2E);
        check("t5_ovf_set", overflow, exp_ovf);
        check("t5_ovf_model", exp_ovf, 1'b1);
        send_byte(8'hF0); send_byte(8'h2E);
        drain("t5");
        check("t5_ovf_sticky", overflow, 1'b1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check("t5_ovf_clr", overflow, exp_ovf);

        // 6: push into full FIFO coinciding with a pop is not an overflow.
        ev.ev_ready = 1'b0;
        press(8'h16); press(8'h1E); press(8'h26); press(8'h25);
        @(negedge clk);
        rx_data  = 8'h1C;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid    = 1'b0;
        ev.ev_ready = 1'b1;
        @(negedge clk);
        ev.ev_ready = 1'b0;
        model_byte(8'h1C);
        check("t6_no_ovf", overflow, 1'b0);
        check("t6_still_full", ev.ev_valid, 1'b1);
        drain("t6");

        // 6b: reset mid-sequence discards queued event, shift and the pending break prefix.
        ev.ev_ready = 1'b0;
        send_byte(8'h12);
        send_byte(8'h16);
        send_byte(8'hF0);
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        #1;
        check("mid_rst_letter_case", letter_case, 1'b0);
        check("mid_rst_scan_code", scan_code, 8'h00);
        check("mid_rst_ev_valid", ev.ev_valid, 1'b0);
        check("mid_rst_ev_ascii", ev.ev_ascii, 8'h00);
        check("mid_rst_overflow", overflow, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        send_byte(8'h46);
        check("post_rst_ev_ascii", ev.ev_ascii, 8'h39);
        drain("t6b");

        // Random traffic: mostly spaced bytes, some back-to-back bursts.
        ev.ev_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int j = 0; j < int'($urandom_range(2, 4)); j++)
                    burst_q.push_back(pool[$urandom_range(0, 19)]);
                do_burst();
            end else begin
                send_byte(pool[$urandom_range(0, 19)]);
            end
        end
        drain("rand");
        check("rand_overflow", overflow, exp_ovf);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
Sequences the PS/2 scan-code stream between the byte receiver and the combinational scan-code-to-ASCII translator.
- Strips make/break/extended prefixes and tracks shift state to drive the translator's letter_case.
- Suppresses typematic repeats and looks up each fresh make code.
- Queues non-NUL ASCII results in a small FIFO, read by the game logic over a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, event queue entries; power of two, >=2.

Ports:
clk  input  1  system clock, all state on rising edge.
resetn  input  1  asynchronous active-low reset.
rx_data  input  8  byte from PS/2 receiver.
rx_valid  input  1  one-cycle strobe, rx_data valid.
letter_case  output  1  to translator; 1 while either shift key is held.
scan_code  output  8  to translator; registered make code under lookup.
ascii_code  input  8  from translator; combinational function of scan_code and letter_case; 8'h00 = unmapped.
ev_valid  output  1  FIFO non-empty.
ev_ascii  output  8  head-of-FIFO ASCII, show-ahead.
ev_ready  input  1  consumer accepts head when ev_valid=1.
overflow  output  1  sticky, an event was dropped because the FIFO was full.
ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset values (async, resetn=0): letter_case=0, scan_code=8'h00, ev_valid=0, ev_ascii=8'h00, overflow=0; FSM=IDLE; shift_l=shift_r=0; held_valid=0; lookup_pend=0; FIFO empty.
- Prefix FSM advances only on rx_valid=1. States are IDLE, BRK, EXT, EXT_BRK.
  - IDLE: F0->BRK; E0->EXT; other bytes are handled as a make code, FSM stays in IDLE.
  - BRK: byte handled as a break code ->IDLE.
  - EXT: F0->EXT_BRK; any other byte is discarded ->IDLE.
  - EXT_BRK: any byte is discarded ->IDLE.
  - Extended keys never affect shift or lookups.
- Control bytes 00, AA, EE, FA, FC, FD, FE, FF in any state: discarded, FSM->IDLE.
  - AA (self-test pass) additionally clears shift_l, shift_r and held_valid.
- Make code handling:
  - 12 sets shift_l; 59 sets shift_r. Neither is looked up.
  - A code equal to held_code while held_valid=1 is a typematic repeat and is discarded.
  - Any other code: held_code<=code, held_valid<=1, scan_code<=code, lookup_pend<=1.
- Break code handling:
  - 12 clears shift_l; 59 clears shift_r.
  - A code equal to held_code clears held_valid.
  - Other codes: no effect.
- letter_case = shift_l | shift_r, registered, same cycle as the shift flag update.
- Lookup stage:
  - In the cycle after the accepted make (lookup_pend=1), sample ascii_code.
  - If non-zero, push to FIFO; if 8'h00, drop silently. lookup_pend then clears.
  - Latency: rx_valid at edge t -> ev_valid=1 at edge t+2 when the FIFO was empty.
  - A new rx byte arriving during lookup is processed normally. The pipeline accepts back-to-back rx_valid.
- FIFO:
  - Pop when ev_valid & ev_ready.
  - Push when full with no pop: event dropped, overflow<=1.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push into empty: ev_valid next cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- overflow: set has priority over ovf_clr in the same cycle.
- Reset mid-operation: all state cleared immediately. A partially received prefix sequence and any pending lookup are lost.

Test Plan:
1. Bytes 16, F0, 16 (gap 3 cycles) -> scan_code=16, one event ev_ascii=31 at t+2; break produces nothing; held_valid ends 0.
2. Bytes 22, 22, 22, F0, 22, 22 -> exactly two events of 78: first make plus re-press after break; repeats suppressed.
3. Bytes 12, 44, F0, 44, F0, 12 -> letter_case=1 during the 44 lookup, clears after F0 12; one event if translator returns non-zero, none if 00. Also E0 12 -> letter_case unchanged.
4. Bytes E0, 75, E0, F0, 75, then 1E -> no events for 75; single event 32; FSM in IDLE.
5. ev_ready=0, press 16,1E,26,25,2E (releases between) with FIFO_DEPTH=4 -> four events queued, fifth dropped, overflow=1. Then ev_ready=1 -> 31,32,33,34 in order. ovf_clr -> overflow=0.
6. FIFO full with ev_ready=1 and a lookup push in the same cycle -> no overflow, occupancy stays 4. Then resetn low mid-sequence after F0 -> all outputs at reset values; next 46 yields 39.
